// File: rtl/mem_sample_reader_if.sv
// Sample-memory read port plus the sample stream towards the datapath.
// master: the reader (drives the memory port and the sample stream).
// slave:  the memory/consumer side.
interface mem_sample_reader_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int EPOCH_W = 8
);
  logic               mem_ena;
  logic               wr_rd;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  mem_data;

  logic               smp_valid;
  logic [DATA_W-1:0]  smp_data;
  logic               smp_last;
  logic [EPOCH_W-1:0] smp_epoch;
  logic               smp_ready;

  modport master (
    output mem_ena, wr_rd, addr,
    input  mem_data,
    output smp_valid, smp_data, smp_last, smp_epoch,
    input  smp_ready
  );

  modport slave (
    input  mem_ena, wr_rd, addr,
    output mem_data,
    input  smp_valid, smp_data, smp_last, smp_epoch,
    output smp_ready
  );
endinterface

// File: rtl/mem_sample_reader.sv
// Streaming read sequencer for the single-port sample memories.
// Reads addresses 0..N-1 for E epochs and hands the words to the datapath
// over valid/ready, through a 2-entry skid FIFO sized for the 1-cycle read.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; degenerate starts only pulse done
// ST_RUN   | issuing reads while FIFO occupancy + in-flight stays below 2
// ST_DRAIN | all reads issued; waiting for FIFO and in-flight to empty
module mem_sample_reader #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int EPOCH_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     num_samples,
  input  logic [EPOCH_W-1:0]  num_epochs,
  mem_sample_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    n_q;
  logic [EPOCH_W-1:0] e_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [EPOCH_W-1:0] rd_epoch_q;
  logic               inflight_q;
  logic               tag_last_q;
  logic [EPOCH_W-1:0] tag_epoch_q;
  logic               deg_done_q;

  logic [DATA_W-1:0]  fifo_data_q  [2];
  logic               fifo_last_q  [2];
  logic [EPOCH_W-1:0] fifo_epoch_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         occ_q;

  logic               fifo_valid, pop, issue, launch, degenerate;
  logic               addr_is_last, epoch_is_last;
  logic [2:0]         pending;

  assign fifo_valid    = (occ_q != 2'd0);
  assign pop           = fifo_valid & bus.smp_ready;
  assign pending       = {1'b0, occ_q} + {2'b00, inflight_q};
  // Compare in ADDR_W+1 bits so N = 2^ADDR_W ends at the all-ones address.
  assign addr_is_last  = ({1'b0, rd_addr_q} == (n_q - (ADDR_W+1)'(1)));
  assign epoch_is_last = (rd_epoch_q == (e_q - EPOCH_W'(1)));
  assign degenerate    = (num_samples == '0) || (num_epochs == '0);
  assign launch        = (state_q == ST_IDLE) && start && !degenerate;

  assign bus.wr_rd     = 1'b0;
  assign bus.mem_ena   = issue;
  assign bus.addr      = issue ? rd_addr_q : '0;
  assign bus.smp_valid = fifo_valid;
  assign bus.smp_data  = fifo_data_q[rd_ptr_q];
  assign bus.smp_last  = fifo_last_q[rd_ptr_q];
  assign bus.smp_epoch = fifo_epoch_q[rd_ptr_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, read issue and run status. A pop this cycle frees a slot
  // for an issue in the same cycle, so ready may gate mem_ena directly.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = deg_done_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (pending < (3'd2 + {2'b00, pop})) begin
          issue = 1'b1;
          if (addr_is_last && epoch_is_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run parameters, read address/epoch counters and the in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= '0;
      e_q         <= '0;
      rd_addr_q   <= '0;
      rd_epoch_q  <= '0;
      inflight_q  <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_epoch_q <= '0;
      deg_done_q  <= 1'b0;
    end else begin
      deg_done_q  <= (state_q == ST_IDLE) && start && degenerate;
      inflight_q  <= issue;
      tag_last_q  <= addr_is_last;
      tag_epoch_q <= rd_epoch_q;
      if (launch) begin
        n_q        <= num_samples;
        e_q        <= num_epochs;
        rd_addr_q  <= '0;
        rd_epoch_q <= '0;
      end else if (issue) begin
        if (addr_is_last) begin
          rd_addr_q  <= '0;
          rd_epoch_q <= rd_epoch_q + EPOCH_W'(1);
        end else begin
          rd_addr_q  <= rd_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Output FIFO: capture the read word one cycle after its issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_last_q[i]  <= 1'b0;
        fifo_epoch_q[i] <= '0;
      end
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q]  <= bus.mem_data;
        fifo_last_q[wr_ptr_q]  <= tag_last_q;
        fifo_epoch_q[wr_ptr_q] <= tag_epoch_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_sample_reader.sv
// Bench for mem_sample_reader: behavioural memory plus an expected-sample
// queue built directly from the memory contents, N and E.
module tb_mem_sample_reader;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int EPOCH_W = 8;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               last;
    logic [EPOCH_W-1:0] epoch;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W:0]    num_samples;
  logic [EPOCH_W-1:0] num_epochs;
  logic               busy, done;

  logic [DATA_W-1:0]  mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  mem_sample_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .EPOCH_W(EPOCH_W)) bus ();

  mem_sample_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .EPOCH_W(EPOCH_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .num_epochs  (num_epochs),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Single-port memory with a registered read.
  always @(posedge clk) begin
    if (bus.mem_ena === 1'b1) bus.mem_data <= mem[bus.addr];
  end

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(3 * i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
  endtask

  // Run one pass and check every cycle. mode: 0 ready=1, 1 ready 1,0,0 repeating,
  // 2 random ready. restart_cyc>0 pulses start (with other N/E) mid-run.
  task automatic run_stream(input int n, input int e, input int mode, input int restart_cyc,
                            output int first_issue, output int first_valid, output int done_cyc);
    exp_t q[$];
    exp_t x;
    int issues = 0, xfers = 0, last_xfer = -1, cyc = 0;
    int budget = n * e * 4 + 50;
    bit fin = 0, prev_stall = 0;
    logic [DATA_W-1:0]  pd;
    logic               pl;
    logic [EPOCH_W-1:0] pe;
    first_issue = -1; first_valid = -1; done_cyc = -1;
    pd = '0; pl = 1'b0; pe = '0;
    for (int ep = 0; ep < e; ep++)
      for (int i = 0; i < n; i++) begin
        x.data = mem[i]; x.last = (i == n - 1); x.epoch = EPOCH_W'(ep);
        q.push_back(x);
      end
    @(negedge clk);
    num_samples = (ADDR_W+1)'(n); num_epochs = EPOCH_W'(e); start = 1'b1;
    @(posedge clk);
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start       = (cyc == restart_cyc);
      num_samples = (ADDR_W+1)'($urandom_range(1, 200));
      num_epochs  = EPOCH_W'($urandom_range(1, 9));
      case (mode)
        0:       bus.smp_ready = 1'b1;
        1:       bus.smp_ready = ((cyc % 3) == 1);
        default: bus.smp_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      n_cmp++;
      if (bus.wr_rd !== 1'b0) begin
        n_err++; $display("FAIL wr_rd cyc=%0d got=%b want=0", cyc, bus.wr_rd);
      end
      if (prev_stall) begin
        n_cmp++;
        if (bus.smp_valid !== 1'b1 || bus.smp_data !== pd || bus.smp_last !== pl || bus.smp_epoch !== pe) begin
          n_err++;
          $display("FAIL hold cyc=%0d got v=%b d=%h l=%b e=%0d want v=1 d=%h l=%b e=%0d",
                   cyc, bus.smp_valid, bus.smp_data, bus.smp_last, bus.smp_epoch, pd, pl, pe);
        end
      end
      if (bus.mem_ena === 1'b1) begin
        if (first_issue < 0) first_issue = cyc;
        n_cmp++;
        if (issues >= n * e) begin
          n_err++; $display("FAIL extra_issue cyc=%0d got addr=%0d want no issue", cyc, bus.addr);
        end else if (bus.addr !== ADDR_W'(issues % n)) begin
          n_err++; $display("FAIL addr cyc=%0d got=%0d want=%0d", cyc, bus.addr, issues % n);
        end
        issues++;
      end
      if (bus.smp_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (bus.smp_valid === 1'b1 && bus.smp_ready === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL extra_sample cyc=%0d got d=%h want none", cyc, bus.smp_data);
        end else begin
          x = q.pop_front();
          if (bus.smp_data !== x.data || bus.smp_last !== x.last || bus.smp_epoch !== x.epoch) begin
            n_err++;
            $display("FAIL sample cyc=%0d got d=%h l=%b e=%0d want d=%h l=%b e=%0d",
                     cyc, bus.smp_data, bus.smp_last, bus.smp_epoch, x.data, x.last, x.epoch);
          end
        end
        xfers++; last_xfer = cyc;
      end
      n_cmp++;
      if (issues - xfers > 2) begin
        n_err++; $display("FAIL outstanding cyc=%0d got=%0d want<=2", cyc, issues - xfers);
      end
      prev_stall = (bus.smp_valid === 1'b1) && (bus.smp_ready === 1'b0);
      pd = bus.smp_data; pl = bus.smp_last; pe = bus.smp_epoch;
      if (done === 1'b1) begin
        fin = 1; done_cyc = cyc;
        n_cmp++;
        if (xfers != n * e) begin
          n_err++; $display("FAIL done_count got=%0d want=%0d", xfers, n * e);
        end
        n_cmp++;
        if (cyc != last_xfer + 1) begin
          n_err++; $display("FAIL done_timing got=%0d want=%0d", cyc, last_xfer + 1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL busy_at_done got=%b want=0", busy);
        end
      end else begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++; $display("FAIL busy_run cyc=%0d got=%b want=1", cyc, busy);
        end
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL timeout n=%0d e=%0d got xfers=%0d want done", n, e, xfers);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.smp_valid !== 1'b0) begin
      n_err++; $display("FAIL post_done got done=%b busy=%b v=%b want 0/0/0", done, busy, bus.smp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_samples = '0; num_epochs = '0; bus.smp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (bus.mem_ena !== 1'b0 || bus.wr_rd !== 1'b0 || bus.addr !== '0) begin
      n_err++; $display("FAIL reset_mem got ena=%b wr_rd=%b addr=%0d want 0/0/0", bus.mem_ena, bus.wr_rd, bus.addr);
    end
    n_cmp++;
    if (bus.smp_valid !== 1'b0 || bus.smp_data !== '0 || bus.smp_last !== 1'b0 || bus.smp_epoch !== '0) begin
      n_err++; $display("FAIL reset_smp got v=%b d=%h l=%b e=%0d want all 0", bus.smp_valid, bus.smp_data, bus.smp_last, bus.smp_epoch);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_status got busy=%b done=%b want 0/0", busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int fi, fv, dc;
    fill_ramp();
    run_stream(4, 1, 0, 0, fi, fv, dc);
    n_cmp++;
    if (fi != 1) begin n_err++; $display("FAIL basic_first_issue got=%0d want=1", fi); end
    n_cmp++;
    if (fv != 3) begin n_err++; $display("FAIL basic_first_valid got=%0d want=3", fv); end
    n_cmp++;
    if (dc != 7) begin n_err++; $display("FAIL basic_done got=%0d want=7", dc); end
  endtask

  task automatic test_backpressure();
    int fi, fv, dc;
    fill_random();
    run_stream(8, 1, 1, 5, fi, fv, dc);
    run_stream(17, 2, 2, 9, fi, fv, dc);
  endtask

  task automatic test_multi_epoch();
    int fi, fv, dc;
    fill_ramp();
    run_stream(3, 3, 0, 0, fi, fv, dc);
    n_cmp++;
    if (dc != 12) begin n_err++; $display("FAIL multi_done got=%0d want=12", dc); end
    run_stream(3, 3, 2, 0, fi, fv, dc);
  endtask

  task automatic test_full_depth();
    int fi, fv, dc;
    fill_random();
    run_stream(DEPTH, 2, 0, 0, fi, fv, dc);
    n_cmp++;
    if (dc != 2 * DEPTH + 3) begin n_err++; $display("FAIL full_done got=%0d want=%0d", dc, 2 * DEPTH + 3); end
  endtask

  task automatic test_degenerate();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      num_samples = (k == 0) ? '0 : (ADDR_W+1)'(7);
      num_epochs  = (k == 0) ? EPOCH_W'(4) : '0;
      start = 1'b1; bus.smp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; #1;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || bus.mem_ena !== 1'b0) begin
        n_err++; $display("FAIL degen_done k=%0d got done=%b busy=%b ena=%b want 1/0/0", k, done, busy, bus.mem_ena);
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || bus.mem_ena !== 1'b0 || bus.smp_valid !== 1'b0) begin
          n_err++; $display("FAIL degen_idle k=%0d got done=%b ena=%b v=%b want 0/0/0", k, done, bus.mem_ena, bus.smp_valid);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int fi, fv, dc;
    fill_random();
    @(negedge clk);
    num_samples = (ADDR_W+1)'(8); num_epochs = EPOCH_W'(1); start = 1'b1; bus.smp_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); start = 1'b0; #1;
    end
    n_cmp++;
    if (bus.mem_ena !== 1'b1 || bus.addr !== ADDR_W'(2)) begin
      n_err++; $display("FAIL abort_pre got ena=%b addr=%0d want 1/2", bus.mem_ena, bus.addr);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if (bus.mem_ena !== 1'b0 || bus.addr !== '0 || bus.smp_valid !== 1'b0 || bus.smp_data !== '0 ||
        bus.smp_last !== 1'b0 || bus.smp_epoch !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_outputs got ena=%b addr=%0d v=%b d=%h l=%b e=%0d busy=%b done=%b want all 0",
               bus.mem_ena, bus.addr, bus.smp_valid, bus.smp_data, bus.smp_last, bus.smp_epoch, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bus.smp_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL abort_stale got v=%b done=%b busy=%b want 0/0/0", bus.smp_valid, done, busy);
      end
    end
    run_stream(5, 2, 2, 0, fi, fv, dc);
    n_cmp++;
    if (fi != 1) begin n_err++; $display("FAIL abort_restart got=%0d want=1", fi); end
  endtask

  task automatic test_random();
    int fi, fv, dc;
    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_stream($urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(0, 2), 0, fi, fv, dc);
    end
  endtask

  initial begin
    bus.mem_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_multi_epoch();
    test_full_depth();
    test_degenerate();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
